// File: rtl/shot_scheduler.sv
// shot_scheduler: arbitrates player and alien shots into one bullet engine.
// Build option SHOT_LFSR_EN: alien column search seeded by an 8-bit LFSR.

module shot_scheduler #(
  parameter int N_COL           = 8,
  parameter int COL_PITCH       = 40,
  parameter int ALIEN_PERIOD    = 60,
  parameter int PLAYER_COOLDOWN = 20,
  parameter int ARM_TIMEOUT     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             fire_btn,
  input  logic [N_COL-1:0] alien_alive,
  input  logic [9:0]       alien_base_x,
  input  logic [8:0]       alien_bottom_y,
  input  logic             bullet_active,
  output logic             fire_player,
  output logic             fire_alien,
  output logic [9:0]       alien_x,
  output logic [8:0]       alien_y,
  output logic [3:0]       sel_col,
  output logic             busy
);

  localparam int CW = $clog2(PLAYER_COOLDOWN + 2);
  localparam int VW = $clog2(ALIEN_PERIOD + 1);
  localparam int AW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [9:0] PITCH = 10'(COL_PITCH);

  typedef enum logic [1:0] {IDLE, ARM, FLIGHT} state_e;

  state_e        state_q, state_d;
  logic          kind_q, kind_d;
  logic [AW-1:0] arm_q, arm_d;
  logic          btn_q;
  logic          pp_q, pp_d;
  logic          ap_q, ap_d;
  logic [CW-1:0] cool_q, cool_d;
  logic [VW-1:0] vol_q, vol_d;
  logic [3:0]    ptr_q, ptr_d;
  logic          fp_q, fp_d;
  logic          fa_q, fa_d;
  logic [9:0]    x_q, x_d;
  logic [8:0]    y_q, y_d;
  logic [3:0]    col_q, col_d;

  logic          ack_p, ack_a, rise;
  logic [3:0]    srch_start, col_c;
  logic          found;
  logic [4:0]    idx;
  logic [15:0]   alive16;

`ifdef SHOT_LFSR_EN
  logic [7:0] lfsr_q;

  // Fibonacci LFSR (taps 8,6,5,4) stepping once per tick
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 8'hA5;
    end else if (tick) begin
      lfsr_q <= {lfsr_q[6:0],
                 lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign srch_start = 4'(32'(lfsr_q[3:0]) % N_COL);
`else
  assign srch_start = (ptr_q == 4'(N_COL - 1)) ? 4'd0 : ptr_q + 4'd1;
`endif

  // Rotating search for the first living column from srch_start
  always_comb begin
    alive16 = '0;
    alive16[N_COL-1:0] = alien_alive;
    found = 1'b0;
    col_c = '0;
    idx = '0;
    for (int i = N_COL - 1; i >= 0; i--) begin
      idx = 5'(srch_start) + 5'(i);
      if (idx >= 5'(N_COL)) idx = idx - 5'(N_COL);
      if (alive16[idx[3:0]]) begin
        found = 1'b1;
        col_c = idx[3:0];
      end
    end
  end

  // FSM next state, issue strobes, pending flags and counters
  always_comb begin
    state_d = state_q;
    kind_d  = kind_q;
    arm_d   = arm_q;
    fp_d    = 1'b0;
    fa_d    = 1'b0;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    ptr_d   = ptr_q;
    ack_p   = 1'b0;
    ack_a   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pp_q && !bullet_active) begin
          fp_d    = 1'b1;
          kind_d  = 1'b1;
          arm_d   = '0;
          state_d = ARM;
        end else if (ap_q && !bullet_active && found) begin
          fa_d    = 1'b1;
          kind_d  = 1'b0;
          arm_d   = '0;
          x_d     = alien_base_x + 10'(col_c) * PITCH;
          y_d     = alien_bottom_y + 9'd8;
          col_d   = col_c;
          state_d = ARM;
        end
      end
      ARM: begin
        if (bullet_active) begin
          state_d = FLIGHT;
          if (kind_q) begin
            ack_p = 1'b1;
          end else begin
            ack_a = 1'b1;
            ptr_d = col_q;
          end
        end else if (arm_q == AW'(ARM_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          arm_d = arm_q + AW'(1);
        end
      end
      FLIGHT: begin
        if (!bullet_active) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rise = fire_btn & ~btn_q;
    pp_d = pp_q;
    if (rise && cool_q == '0) pp_d = 1'b1;
    if (ack_p) pp_d = 1'b0;

    cool_d = cool_q;
    if (ack_p) cool_d = CW'(PLAYER_COOLDOWN);
    else if (tick && cool_q != '0) cool_d = cool_q - CW'(1);

    vol_d = vol_q;
    ap_d  = ap_q;
    if (ack_a) ap_d = 1'b0;
    if (tick) begin
      if (vol_q == VW'(ALIEN_PERIOD - 1)) begin
        vol_d = '0;
        ap_d  = 1'b1;
      end else begin
        vol_d = vol_q + VW'(1);
      end
    end
    if (alien_alive == '0) ap_d = 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      kind_q  <= 1'b0;
      arm_q   <= '0;
      btn_q   <= 1'b0;
      pp_q    <= 1'b0;
      ap_q    <= 1'b0;
      cool_q  <= '0;
      vol_q   <= '0;
      ptr_q   <= 4'(N_COL - 1);
      fp_q    <= 1'b0;
      fa_q    <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      kind_q  <= kind_d;
      arm_q   <= arm_d;
      btn_q   <= fire_btn;
      pp_q    <= pp_d;
      ap_q    <= ap_d;
      cool_q  <= cool_d;
      vol_q   <= vol_d;
      ptr_q   <= ptr_d;
      fp_q    <= fp_d;
      fa_q    <= fa_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
    end
  end

  assign fire_player = fp_q;
  assign fire_alien  = fa_q;
  assign alien_x     = x_q;
  assign alien_y     = y_q;
  assign sel_col     = col_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_shot_scheduler.sv
// tb_shot_scheduler: randomized scoreboard bench for shot_scheduler.
// Engine model acks strobes one cycle later; reference model predicts shots.
`timescale 1ns/1ps

module tb_shot_scheduler;

  localparam int N_COL    = 8;
  localparam int PITCH    = 40;
  localparam int PERIOD   = 60;
  localparam int COOL     = 20;
  localparam int TIMEOUT  = 4;

  typedef struct {
    bit         player;
    logic [3:0] col;
    logic [9:0] x;
    logic [8:0] y;
  } shot_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       fire_btn;
  logic [7:0] alien_alive;
  logic [9:0] alien_base_x;
  logic [8:0] alien_bottom_y;
  logic       bullet_active;
  logic       fire_player;
  logic       fire_alien;
  logic [9:0] alien_x;
  logic [8:0] alien_y;
  logic [3:0] sel_col;
  logic       busy;

  int checks = 0;
  int errors = 0;
  shot_t exp_q[$];
  longint p_times[$];
  int n_player = 0;
  int n_alien = 0;
  bit ack_en = 1'b1;
  int hold_len = 30;
  bit p_ack = 1'b0;

  // reference model state
  int m_vol = 0;
  int m_ptr = N_COL - 1;
  bit m_pp = 1'b0;
  bit m_btn = 1'b0;
  bit m_acked = 1'b0;
  int m_since = 0;

  shot_scheduler #(
    .N_COL(N_COL), .COL_PITCH(PITCH), .ALIEN_PERIOD(PERIOD),
    .PLAYER_COOLDOWN(COOL), .ARM_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .fire_btn(fire_btn),
    .alien_alive(alien_alive), .alien_base_x(alien_base_x),
    .alien_bottom_y(alien_bottom_y), .bullet_active(bullet_active),
    .fire_player(fire_player), .fire_alien(fire_alien),
    .alien_x(alien_x), .alien_y(alien_y), .sel_col(sel_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", nm, act, req);
    end
  endtask

  function automatic int next_col(input logic [7:0] alive,
                                  input int ptr);
    for (int k = 1; k <= N_COL; k++) begin
      int c = (ptr + k) % N_COL;
      if (alive[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: decides which shots must appear, in order
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_vol = 0; m_ptr = N_COL - 1; m_pp = 0;
      m_acked = 0; m_since = 0;
    end else begin
      if (fire_btn && !m_btn && !m_pp &&
          (!m_acked || m_since >= COOL)) begin
        shot_t s;
        s.player = 1; s.col = 0; s.x = 0; s.y = 0;
        m_pp = 1;
        exp_q.push_back(s);
      end
      if (p_ack) begin
        m_pp = 0; m_acked = 1; m_since = 0;
      end else if (tick) begin
        m_since++;
      end
      if (tick) begin
        m_vol++;
        if (m_vol == PERIOD) begin
          int c;
          m_vol = 0;
          c = next_col(alien_alive, m_ptr);
          if (c >= 0) begin
            shot_t s;
            s.player = 0;
            s.col = 4'(c);
            s.x = 10'((int'(alien_base_x) + c * PITCH) % 1024);
            s.y = 9'((int'(alien_bottom_y) + 8) % 512);
            m_ptr = c;
            exp_q.push_back(s);
          end
        end
      end
    end
    m_btn = reset ? 1'b0 : fire_btn;
  end

  // Bullet engine: raises active the cycle after a strobe, holds it
  initial begin
    bit fp, fa;
    int cnt;
    bullet_active = 0;
    cnt = 0;
    forever begin
      @(negedge clk);
      fp = fire_player;
      fa = fire_alien;
      @(posedge clk);
      #1;
      p_ack = 0;
      if ((fp || fa) && ack_en) begin
        bullet_active = 1;
        cnt = hold_len;
        p_ack = fp;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) bullet_active = 0;
      end
    end
  end

  // Monitor: pops one expectation per issued strobe
  initial forever begin
    @(negedge clk);
    if (fire_player || fire_alien) begin
      check("one_strobe", 64'(fire_player & fire_alien), 0);
      check("engine_quiet", 64'(bullet_active), 0);
      if (fire_player) begin
        n_player++;
        p_times.push_back(longint'($time));
      end else begin
        n_alien++;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got player=%0b alien=%0b, required none",
                 fire_player, fire_alien);
      end else begin
        shot_t e;
        e = exp_q.pop_front();
        check("shot_kind", 64'(fire_player), 64'(e.player));
        if (!e.player) begin
          check("sel_col", 64'(sel_col), 64'(e.col));
          check("alien_x", 64'(alien_x), 64'(e.x));
          check("alien_y", 64'(alien_y), 64'(e.y));
        end
        if (!ack_en) exp_q.push_front(e);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1;
      @(negedge clk);
    end
    tick = 0;
  endtask

  task automatic press();
    fire_btn = 1;
    @(negedge clk);
    fire_btn = 0;
    @(negedge clk);
  endtask

  task automatic drain(input int maxc, input string nm);
    int i;
    bit done;
    i = 0;
    done = 0;
    while (i < maxc && !done) begin
      done = (exp_q.size() == 0) && !bullet_active && !busy;
      if (!done) begin
        @(negedge clk);
        i++;
      end
    end
    check(nm, 64'(done), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_fp"}, 64'(fire_player), 0);
    check({tag, "_fa"}, 64'(fire_alien), 0);
    check({tag, "_x"}, 64'(alien_x), 0);
    check({tag, "_y"}, 64'(alien_y), 0);
    check({tag, "_col"}, 64'(sel_col), 0);
    check({tag, "_busy"}, 64'(busy), 0);
  endtask

  initial begin
    longint t0;
    int np, na, i;
    reset = 1; tick = 0; fire_btn = 0;
    alien_alive = 8'hFF;
    alien_base_x = 10'd100;
    alien_bottom_y = 9'd200;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 0;

    // first two volleys: columns 0 then 1
    ticks(PERIOD);
    drain(300, "volley1_drain");
    check("volley1_col", 64'(sel_col), 0);
    check("volley1_x_held", 64'(alien_x), 100);
    check("volley1_y_held", 64'(alien_y), 208);
    ticks(PERIOD);
    drain(300, "volley2_drain");
    check("volley2_col", 64'(sel_col), 1);
    check("volley2_x_held", 64'(alien_x), 140);

    // random volleys
    for (int k = 0; k < 6; k++) begin
      alien_alive = 8'($urandom_range(1, 255));
      alien_base_x = 10'($urandom);
      alien_bottom_y = 9'($urandom);
      hold_len = $urandom_range(2, 30);
      ticks(PERIOD);
      drain(300, "rand_volley_drain");
    end

    // sparse row: column 2, then 7, then 2 again
    hold_len = 30;
    alien_alive = 8'b0000_0100;
    ticks(PERIOD);
    drain(300, "sparse_a_drain");
    alien_alive = 8'b1000_0100;
    ticks(PERIOD);
    drain(300, "sparse_b_drain");
    check("sparse_col7", 64'(sel_col), 7);
    ticks(PERIOD);
    drain(300, "sparse_c_drain");
    check("sparse_col2", 64'(sel_col), 2);

    // no living aliens: request dropped
    alien_alive = 8'h00;
    ticks(PERIOD);
    na = n_alien;
    alien_alive = 8'hFF;
    repeat (10) @(negedge clk);
    check("dead_row_no_volley", 64'(n_alien), 64'(na));

    // press and volley request in the same cycle
    ticks(PERIOD - 1);
    np = p_times.size();
    na = n_alien;
    tick = 1;
    fire_btn = 1;
    t0 = longint'($time);
    @(negedge clk);
    tick = 0;
    fire_btn = 0;
    drain(300, "prio_drain");
    check("prio_latency",
          (p_times.size() > np) ? 64'(p_times[np] - t0) : 64'(0), 20);
    check("prio_alien_after", 64'(n_alien), 64'(na + 1));

    // cooldown: presses at 5 and 19 ticks dropped, at 20 accepted
    np = n_player;
    ticks(5);
    press();
    ticks(14);
    press();
    repeat (4) @(negedge clk);
    check("cooldown_dropped", 64'(n_player), 64'(np));
    ticks(1);
    np = p_times.size();
    t0 = longint'($time);
    press();
    drain(300, "cooldown_drain");
    check("cooldown_latency",
          (p_times.size() > np) ? 64'(p_times[np] - t0) : 64'(0), 20);

    // random press timing against cooldown and volleys
    for (int k = 0; k < 10; k++) begin
      hold_len = $urandom_range(2, 30);
      alien_alive = 8'($urandom_range(0, 255));
      ticks($urandom_range(0, 25));
      drain(300, "rand_pre_drain");
      press();
    end
    drain(300, "rand_press_drain");

    // engine never acknowledges: issue retried after timeout
    hold_len = 30;
    alien_alive = 8'hFF;
    ticks(25);
    drain(300, "timeout_pre_drain");
    np = n_player;
    ack_en = 0;
    press();
    i = 0;
    while (i < 40 && n_player < np + 2) begin
      @(negedge clk);
      i++;
    end
    @(negedge clk);
    ack_en = 1;
    check("timeout_retry_seen", 64'(n_player >= np + 2), 1);
    check("timeout_retry_gap",
          (n_player >= np + 2) ?
            64'(p_times[np + 1] - p_times[np]) : 64'(0),
          10 * (TIMEOUT + 1));
    drain(300, "timeout_drain");
    check("timeout_acked_third", 64'(n_player), 64'(np + 3));

    // reset while a shot is in flight
    ticks(25);
    drain(300, "flight_pre_drain");
    press();
    i = 0;
    while (i < 20 && !(bullet_active && busy)) begin
      @(negedge clk);
      i++;
    end
    check("flight_reached", 64'(bullet_active && busy), 1);
    repeat (3) @(negedge clk);
    reset = 1;
    @(negedge clk);
    check_reset_outputs("midflight");
    reset = 0;
    press();
    repeat (2) @(negedge clk);
    check("hold_while_active_busy", 64'(busy), 0);
    check("hold_while_active_eng", 64'(bullet_active), 1);
    drain(300, "final_drain");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
